cn_axi_mem_responder: RTL and testbench

// AXI4 slave memory responder for the far end of the kernel's 128-bit m00_axi master port.

---
 rtl/cn_axi_pkg.sv | 18 +
 rtl/cn_axi_mem_bram.sv | 31 +++
 rtl/cn_axi_mem_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_cn_axi_mem_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cn_axi_pkg.sv
// Shared constants and state types for the AXI4 memory responder.
package cn_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_16B    = 3'd4;

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_FETCH = 2'd1, RD_DATA = 2'd2} rd_state_t;

  function automatic logic illegal_burst(input logic [2:0] size, input logic [1:0] burst);
    return (size != SIZE_16B) || (burst != BURST_INCR);
  endfunction

endpackage

// File: rtl/cn_axi_mem_bram.sv
// Simple dual-port RAM: byte-enabled write port A, registered read port B, read-first.
module cn_axi_mem_bram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 128
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wbe,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_r [DEPTH];

  // Both ports in one block so a colliding read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
    for (int i = 0; i < DW/8; i++) begin
      if (we && wbe[i]) begin
        mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/cn_axi_mem_responder.sv
// AXI4 slave backed by on-chip RAM; independent single-burst read and write engines.
module cn_axi_mem_responder
  import cn_axi_pkg::*;
#(
  parameter int              ADDR_W    = 64,
  parameter int              DATA_W    = 128,
  parameter int              MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h0
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [15:0]       s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(MEM_DEPTH);

  wr_state_t         wr_state_r;
  logic [ADDR_W-1:0] wr_word_r;
  logic [8:0]        wr_len_r, wr_beat_r;
  logic              wr_ill_r, wr_dec_r, wr_slv_r;
  logic              awready_r, wready_r, bvalid_r;
  logic [1:0]        bresp_r;
  logic              w_hs_s, w_oor_s, w_we_s, w_last_s;

  rd_state_t         rd_state_r;
  logic [ADDR_W-1:0] rd_word_r;
  logic [8:0]        rd_len_r, rd_icnt_r;
  logic              rd_ill_r, arready_r;
  logic              infl_r, infl_last_r;
  logic [1:0]        infl_resp_r;
  logic              rvalid_r, rlast_r, skid_v_r, skid_last_r;
  logic [DATA_W-1:0] rdata_r, skid_data_r;
  logic [1:0]        rresp_r, skid_resp_r;
  logic [DATA_W-1:0] ram_dout_s, arr_data_s;
  logic [1:0]        occ_s;
  logic              r_pop_s, r_oor_s, r_issue_s;

  assign w_hs_s   = wready_r && s_axi_wvalid;
  assign w_oor_s  = wr_word_r >= DEPTH_W;
  assign w_we_s   = w_hs_s && !w_oor_s && !wr_ill_r;
  assign w_last_s = wr_beat_r == wr_len_r;

  // Write engine: AW capture, beat consumption, response generation.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state_r <= WR_IDLE;
      wr_word_r  <= '0;
      wr_len_r   <= 9'd0;
      wr_beat_r  <= 9'd0;
      wr_ill_r   <= 1'b0;
      wr_dec_r   <= 1'b0;
      wr_slv_r   <= 1'b0;
      awready_r  <= 1'b1;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
    end else begin
      case (wr_state_r)
        WR_IDLE: begin
          if (s_axi_awvalid) begin
            wr_word_r  <= (s_axi_awaddr - BASE_ADDR) >> 4'd4;
            wr_len_r   <= {1'b0, s_axi_awlen};
            wr_beat_r  <= 9'd0;
            wr_ill_r   <= illegal_burst(s_axi_awsize, s_axi_awburst);
            wr_dec_r   <= 1'b0;
            wr_slv_r   <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b1;
            wr_state_r <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (w_hs_s) begin
            wr_word_r <= wr_word_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            wr_beat_r <= wr_beat_r + 9'd1;
            if (w_last_s) begin
              wready_r   <= 1'b0;
              bvalid_r   <= 1'b1;
              wr_state_r <= WR_RESP;
              if (wr_dec_r || w_oor_s)
                bresp_r <= RESP_DECERR;
              else if (wr_ill_r || wr_slv_r || !s_axi_wlast)
                bresp_r <= RESP_SLVERR;
              else
                bresp_r <= RESP_OKAY;
            end else begin
              wr_dec_r <= wr_dec_r || w_oor_s;
              wr_slv_r <= wr_slv_r || s_axi_wlast;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wr_state_r <= WR_IDLE;
          end
        end
        default: begin
          wr_state_r <= WR_IDLE;
          awready_r  <= 1'b1;
          wready_r   <= 1'b0;
          bvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Reads are issued only while head + skid + in-flight stays within the two output slots.
  assign r_pop_s    = rvalid_r && s_axi_rready;
  assign occ_s      = {1'b0, rvalid_r} + {1'b0, skid_v_r} + {1'b0, infl_r};
  assign r_oor_s    = rd_word_r >= DEPTH_W;
  assign r_issue_s  = (rd_state_r == RD_FETCH) && ((occ_s - {1'b0, r_pop_s}) < 2'd2);
  assign arr_data_s = (infl_resp_r == RESP_OKAY) ? ram_dout_s : {DATA_W{1'b0}};

  // Read engine: AR capture, beat issue, completion on the accepted last beat.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_state_r  <= RD_IDLE;
      rd_word_r   <= '0;
      rd_len_r    <= 9'd0;
      rd_icnt_r   <= 9'd0;
      rd_ill_r    <= 1'b0;
      arready_r   <= 1'b1;
      infl_r      <= 1'b0;
      infl_last_r <= 1'b0;
      infl_resp_r <= RESP_OKAY;
    end else begin
      infl_r <= r_issue_s;
      if (r_issue_s) begin
        infl_last_r <= rd_icnt_r == rd_len_r;
        infl_resp_r <= r_oor_s ? RESP_DECERR : (rd_ill_r ? RESP_SLVERR : RESP_OKAY);
      end
      case (rd_state_r)
        RD_IDLE: begin
          if (s_axi_arvalid) begin
            rd_word_r  <= (s_axi_araddr - BASE_ADDR) >> 4'd4;
            rd_len_r   <= {1'b0, s_axi_arlen};
            rd_icnt_r  <= 9'd0;
            rd_ill_r   <= illegal_burst(s_axi_arsize, s_axi_arburst);
            arready_r  <= 1'b0;
            rd_state_r <= RD_FETCH;
          end
        end
        RD_FETCH: begin
          if (r_issue_s) begin
            rd_word_r <= rd_word_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            rd_icnt_r <= rd_icnt_r + 9'd1;
            if (rd_icnt_r == rd_len_r) rd_state_r <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_pop_s && rlast_r) begin
            arready_r  <= 1'b1;
            rd_state_r <= RD_IDLE;
          end
        end
        default: begin
          arready_r  <= 1'b1;
          rd_state_r <= RD_IDLE;
        end
      endcase
    end
  end

  // Output register plus one skid entry; head holds steady while stalled.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rvalid_r    <= 1'b0;
      rdata_r     <= '0;
      rresp_r     <= RESP_OKAY;
      rlast_r     <= 1'b0;
      skid_v_r    <= 1'b0;
      skid_data_r <= '0;
      skid_resp_r <= RESP_OKAY;
      skid_last_r <= 1'b0;
    end else if (!rvalid_r || s_axi_rready) begin
      if (skid_v_r) begin
        rvalid_r <= 1'b1;
        rdata_r  <= skid_data_r;
        rresp_r  <= skid_resp_r;
        rlast_r  <= skid_last_r;
        skid_v_r <= infl_r;
        if (infl_r) begin
          skid_data_r <= arr_data_s;
          skid_resp_r <= infl_resp_r;
          skid_last_r <= infl_last_r;
        end
      end else if (infl_r) begin
        rvalid_r <= 1'b1;
        rdata_r  <= arr_data_s;
        rresp_r  <= infl_resp_r;
        rlast_r  <= infl_last_r;
      end else begin
        rvalid_r <= 1'b0;
        rlast_r  <= 1'b0;
      end
    end else if (infl_r) begin
      skid_v_r    <= 1'b1;
      skid_data_r <= arr_data_s;
      skid_resp_r <= infl_resp_r;
      skid_last_r <= infl_last_r;
    end
  end

  cn_axi_mem_bram #(.DEPTH(MEM_DEPTH), .AW(AW), .DW(DATA_W)) u_bram (
    .clk   (ap_clk),
    .we    (w_we_s),
    .waddr (wr_word_r[AW-1:0]),
    .wdata (s_axi_wdata),
    .wbe   (s_axi_wstrb),
    .re    (r_issue_s),
    .raddr (rd_word_r[AW-1:0]),
    .rdata (ram_dout_s)
  );

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rlast   = rlast_r;

endmodule

// File: tb/tb_cn_axi_mem_responder.sv
// Scoreboard bench: a reference memory model predicts responses and read beats.
module tb_cn_axi_mem_responder;
  import cn_axi_pkg::*;

  logic         ap_clk = 1'b0;
  logic         ap_rst_n = 1'b0;
  logic [63:0]  s_axi_awaddr = 64'd0, s_axi_araddr = 64'd0;
  logic [7:0]   s_axi_awlen = 8'd0, s_axi_arlen = 8'd0;
  logic [2:0]   s_axi_awsize = 3'd4, s_axi_arsize = 3'd4;
  logic [1:0]   s_axi_awburst = 2'd1, s_axi_arburst = 2'd1;
  logic         s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic         s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready;
  logic [127:0] s_axi_wdata = 128'd0;
  logic [15:0]  s_axi_wstrb = 16'd0;
  logic         s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
  logic [1:0]   s_axi_bresp, s_axi_rresp;
  logic [127:0] s_axi_rdata;
  logic         s_axi_rlast, s_axi_rvalid;
  logic         s_axi_rready = 1'b0;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
    logic         last;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] mem_m [4096];
  logic [127:0] wd [256];
  logic [15:0]  ws [256];
  int           checks = 0;
  int           failures = 0;

  always #5 ap_clk = ~ap_clk;

  cn_axi_mem_responder dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // wlast_at < 0 means wlast on the true final beat only.
  task automatic axi_write(input logic [63:0] addr, input int len, input logic [1:0] burst,
                           input int wlast_at, input string tag);
    logic [63:0] w;
    logic        ill, dec, slv, hs;
    logic [1:0]  exp_resp;
    int          t;
    ill = (burst != BURST_INCR);
    dec = 1'b0;
    slv = ill;
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = SIZE_16B;
    s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    t = 0;
    do begin hs = s_axi_awready; tick(); t++; end while (!hs && t < 100);
    s_axi_awvalid = 1'b0;
    if (!hs) check({tag, "_aw_tmo"}, 128'd0, 128'd1);
    for (int b = 0; b <= len; b++) begin
      w = (addr >> 4) + 64'(b);
      s_axi_wdata = wd[b]; s_axi_wstrb = ws[b]; s_axi_wvalid = 1'b1;
      s_axi_wlast = (wlast_at < 0) ? (b == len) : (b == wlast_at);
      if ((b == len) != s_axi_wlast) slv = 1'b1;
      if (w >= 64'd4096) dec = 1'b1;
      else if (!ill) begin
        for (int k = 0; k < 16; k++)
          if (ws[b][k]) mem_m[w[11:0]][8*k +: 8] = wd[b][8*k +: 8];
      end
      t = 0;
      do begin hs = s_axi_wready; tick(); t++; end while (!hs && t < 100);
      if (!hs) check({tag, "_w_tmo"}, 128'd0, 128'd1);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    exp_resp = dec ? RESP_DECERR : (slv ? RESP_SLVERR : RESP_OKAY);
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 100) begin tick(); t++; end
    check({tag, "_bresp"}, {126'd0, s_axi_bresp}, {126'd0, exp_resp});
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [63:0] addr, input int len, input bit stall, input string tag);
    exp_t        e;
    logic [63:0] w;
    logic [127:0] held;
    logic        hs, rr, held_v;
    int          t, got, cyc;
    bit          first;
    for (int b = 0; b <= len; b++) begin
      w = (addr >> 4) + 64'(b);
      e.data = (w >= 64'd4096) ? 128'd0 : mem_m[w[11:0]];
      e.resp = (w >= 64'd4096) ? RESP_DECERR : RESP_OKAY;
      e.last = (b == len);
      sb.push_back(e);
    end
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = SIZE_16B;
    s_axi_arburst = BURST_INCR; s_axi_arvalid = 1'b1;
    t = 0;
    do begin hs = s_axi_arready; tick(); t++; end while (!hs && t < 100);
    s_axi_arvalid = 1'b0;
    if (!hs) check({tag, "_ar_tmo"}, 128'd0, 128'd1);
    got = 0; cyc = 0; first = 1'b1; held_v = 1'b0; held = 128'd0;
    while (got <= len && cyc < 3000) begin
      rr = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axi_rready = rr;
      if (s_axi_rvalid) begin
        if (first) check({tag, "_lat"}, 128'(cyc), 128'd2);
        first = 1'b0;
        if (held_v) check({tag, "_stable"}, s_axi_rdata, held);
        if (rr) begin
          e = sb.pop_front();
          check($sformatf("%s_data%0d", tag, got), s_axi_rdata, e.data);
          check($sformatf("%s_resp%0d", tag, got), {126'd0, s_axi_rresp}, {126'd0, e.resp});
          check($sformatf("%s_last%0d", tag, got), {127'd0, s_axi_rlast}, {127'd0, e.last});
          got++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held = s_axi_rdata;
        end
      end
      tick();
      cyc++;
    end
    s_axi_rready = 1'b0;
    if (got <= len) begin
      check({tag, "_r_tmo"}, 128'(got), 128'(len + 1));
      sb.delete();
    end
  endtask

  initial begin
    int acc;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    check("rst_awready", {127'd0, s_axi_awready}, 128'd1);
    check("rst_arready", {127'd0, s_axi_arready}, 128'd1);
    check("rst_wready", {127'd0, s_axi_wready}, 128'd0);
    check("rst_bvalid", {127'd0, s_axi_bvalid}, 128'd0);
    check("rst_rvalid", {127'd0, s_axi_rvalid}, 128'd0);
    check("rst_rlast", {127'd0, s_axi_rlast}, 128'd0);
    check("rst_bresp", {126'd0, s_axi_bresp}, 128'd0);
    check("rst_rresp", {126'd0, s_axi_rresp}, 128'd0);
    check("rst_rdata", s_axi_rdata, 128'd0);
    tick();

    wd[0] = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF; ws[0] = 16'hFFFF;
    axi_write(64'h40, 0, BURST_INCR, -1, "single");
    axi_read(64'h40, 0, 1'b0, "single");

    for (int b = 0; b < 16; b++) begin
      wd[b] = {$urandom, $urandom, $urandom, $urandom}; ws[b] = 16'hFFFF;
    end
    axi_write(64'h1000, 15, BURST_INCR, -1, "b16");
    axi_read(64'h1000, 15, 1'b1, "b16");

    wd[0] = {128{1'b1}}; ws[0] = 16'hFFFF;
    axi_write(64'h200, 0, BURST_INCR, -1, "strb_a");
    wd[0] = 128'd0; ws[0] = 16'h00F0;
    axi_write(64'h200, 0, BURST_INCR, -1, "strb_b");
    check("strb_model", mem_m[12'h020], 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_FFFF_FFFF);
    axi_read(64'h200, 0, 1'b0, "strb");

    wd[0] = 128'hA5A5_0000_1111_2222_3333_4444_5555_A5A5; ws[0] = 16'hFFFF;
    axi_write(64'hFFF0, 0, BURST_INCR, -1, "top_init");
    wd[0] = 128'h0BAD_0000_0000_0000_0000_0000_0000_0001;
    axi_write(64'h0, 0, BURST_INCR, -1, "w0_init");
    axi_read(64'hFFF0, 1, 1'b0, "oor_rd");
    wd[0] = 128'h1234_5678_9ABC_DEF0_1357_9BDF_2468_ACE0; ws[0] = 16'hFFFF;
    wd[1] = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888; ws[1] = 16'hFFFF;
    axi_write(64'hFFF0, 1, BURST_INCR, -1, "oor_wr");
    axi_read(64'hFFF0, 1, 1'b1, "oor_rd2");
    axi_read(64'h0, 0, 1'b0, "no_alias");

    wd[0] = 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC; ws[0] = 16'hFFFF;
    axi_write(64'h300, 0, BURST_INCR, -1, "fixed_init");
    wd[0] = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
    axi_write(64'h300, 0, BURST_FIXED, -1, "fixed");
    axi_read(64'h300, 0, 1'b0, "fixed");
    for (int b = 0; b < 4; b++) begin wd[b] = 128'(b + 7); ws[b] = 16'hFFFF; end
    axi_write(64'h400, 3, BURST_INCR, 1, "early_last");

    for (int b = 0; b < 256; b++) begin
      wd[b] = {$urandom, $urandom, 32'(b), $urandom}; ws[b] = 16'hFFFF;
    end
    axi_write(64'h8000, 255, BURST_INCR, -1, "b256");
    axi_read(64'h8000, 255, 1'b0, "b256");

    s_axi_araddr = 64'h1000; s_axi_arlen = 8'd15; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    acc = 0;
    for (int c = 0; c < 100 && acc < 4; c++) begin
      if (s_axi_rvalid) acc++;
      tick();
    end
    check("mid_acc", 128'(acc), 128'd4);
    check("mid_beat5_valid", {127'd0, s_axi_rvalid}, 128'd1);
    ap_rst_n = 1'b0;
    #1;
    check("mid_rvalid", {127'd0, s_axi_rvalid}, 128'd0);
    check("mid_arready", {127'd0, s_axi_arready}, 128'd1);
    s_axi_rready = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    tick();
    check("post_rst_rvalid", {127'd0, s_axi_rvalid}, 128'd0);
    axi_read(64'h1000, 3, 1'b1, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
